// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder slice.
package nibble_adder_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } nas_state_t;

endpackage

// File: rtl/FourBitParallelAdder.sv
// Shared 4-bit ripple datapath: {Carry, Sum} = A + B + Cin.
module FourBitParallelAdder (
    output logic [3:0] Sum,
    output logic       Carry,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin
);

    assign {Carry, Sum} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide adder built by stepping one 4-bit adder across the operands, LSB nibble first,
// with valid/ready handshakes on both the operand and the result side.
module nibble_serial_adder_ctrl
    import nibble_adder_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
    input  logic                    cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    cout
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    nas_state_t          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [W-1:0]        a_q, a_d;
    logic [W-1:0]        b_q, b_d;
    logic [W-1:0]        sum_q, sum_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;

    logic [NIBBLE_W-1:0] add_a, add_b, add_sum;
    logic                add_carry;

    // Select the active nibble with a compare-per-slice mux to keep index widths exact.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < int'(NIBBLES); i++) begin
            if (cnt_q == CW'(i)) begin
                add_a = a_q[i*NIBBLE_W +: NIBBLE_W];
                add_b = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    FourBitParallelAdder u_adder (add_sum, add_carry, add_a, add_b, carry_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i*NIBBLE_W +: NIBBLE_W] = add_sum;
                    end
                end
                carry_d = add_carry;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cout_d  = add_carry;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
